// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: decode-side controls, imem request/response and decode head outputs.
// The master modport is the fetch_queue side; slave is the environment (imem + decode).
interface fetch_queue_if #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned IWIDTH   = 32
) ();
  logic                f_i_ce;
  logic                f_i_stall;
  logic                f_i_redirect;
  logic [PC_WIDTH-1:0] f_i_redirect_pc;
  logic                f_o_req;
  logic [PC_WIDTH-1:0] f_o_req_addr;
  logic                f_i_req_ready;
  logic                f_i_rsp_valid;
  logic [IWIDTH-1:0]   f_i_rsp_instr;
  logic                f_o_valid;
  logic [PC_WIDTH-1:0] f_o_pc;
  logic [IWIDTH-1:0]   f_o_instr;

  modport master (
    input  f_i_ce, f_i_stall, f_i_redirect, f_i_redirect_pc,
    input  f_i_req_ready, f_i_rsp_valid, f_i_rsp_instr,
    output f_o_req, f_o_req_addr, f_o_valid, f_o_pc, f_o_instr
  );

  modport slave (
    output f_i_ce, f_i_stall, f_i_redirect, f_i_redirect_pc,
    output f_i_req_ready, f_i_rsp_valid, f_i_rsp_instr,
    input  f_o_req, f_o_req_addr, f_o_valid, f_o_pc, f_o_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues in-order imem requests, buffers
// returned words with their PC in a DEPTH-entry queue and presents the head to decode.
// Optional build macro FETCH_PERF_EN adds push/drop performance counter outputs.
module fetch_queue #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter int unsigned         IWIDTH   = 32,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4)
) (
  input logic           d_clk,
  input logic           d_rst,
  fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   f_o_fetch_cnt,
  output logic [31:0]   f_o_drop_cnt
`endif
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [PC_WIDTH-1:0] mem_pc_q [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc_d [DEPTH];
  logic [IWIDTH-1:0]   mem_instr_q [DEPTH];
  logic [IWIDTH-1:0]   mem_instr_d [DEPTH];

  logic            req, accept, push, pop, drop_rsp, head_valid;
  logic [CntW:0]   inflight;

  // Queued plus in-flight words reserve space, so a live response always finds a free slot.
  assign inflight   = {1'b0, count_q} + {1'b0, outst_q};
  assign req        = d_rst & bus.f_i_ce & ~bus.f_i_redirect & (inflight < (CntW + 1)'(DEPTH));
  assign accept     = req & bus.f_i_req_ready;
  assign drop_rsp   = bus.f_i_rsp_valid & (drop_q != '0);
  assign push       = bus.f_i_rsp_valid & ~bus.f_i_redirect & (drop_q == '0);
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & ~bus.f_i_stall & ~bus.f_i_redirect;

  assign bus.f_o_req      = req;
  assign bus.f_o_req_addr = fetch_pc_q;
  assign bus.f_o_valid    = head_valid;
  assign bus.f_o_pc       = head_valid ? mem_pc_q[rd_ptr_q] : '0;
  assign bus.f_o_instr    = head_valid ? mem_instr_q[rd_ptr_q] : '0;

  // Next-state: redirect flushes everything and marks all in-flight words stale.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    drop_d      = drop_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    outst_d     = outst_q + CntW'(accept) - CntW'(bus.f_i_rsp_valid);
    if (bus.f_i_redirect) begin
      fetch_pc_d = bus.f_i_redirect_pc;
      rsp_pc_d   = bus.f_i_redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // A response arriving this cycle is already accounted for by discarding it now.
      drop_d     = outst_q - CntW'(bus.f_i_rsp_valid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (drop_rsp) drop_d = drop_q - CntW'(1);
      if (push) begin
        mem_pc_d[wr_ptr_q]    = rsp_pc_q;
        mem_instr_d[wr_ptr_q] = bus.f_i_rsp_instr;
        wr_ptr_d              = wr_ptr_q + PtrW'(1);
        rsp_pc_d              = rsp_pc_q + PC_STEP;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      mem_pc_q    <= '{default: '0};
      mem_instr_q <= '{default: '0};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, drop_cnt_q, drop_cnt_d;

  // Count queue pushes and every discarded response, including the redirect-cycle word.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(push);
    drop_cnt_d  = drop_cnt_q + 32'(bus.f_i_rsp_valid & (bus.f_i_redirect | (drop_q != '0)));
  end

  // Counter registers, wrapping at 2^32.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign f_o_fetch_cnt = fetch_cnt_q;
  assign f_o_drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: imem model with configurable latency/readiness, a scoreboard of
// expected {pc, instr} pairs filled on request accept and consumed on decode pops.
module tb_fetch_queue;
  logic d_clk = 1'b0;
  logic d_rst = 1'b0;
  always #5 d_clk = ~d_clk;

  fetch_queue_if #(.PC_WIDTH(32), .IWIDTH(32)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, drop_cnt;
`endif

  fetch_queue u_dut (
    .d_clk (d_clk),
    .d_rst (d_rst),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .f_o_fetch_cnt (fetch_cnt),
    .f_o_drop_cnt  (drop_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic [63:0] obs;
    logic [63:0] exp;
  } cmp_t;
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  cmp_t        cmp_q[$];
  logic [63:0] exp_q[$];
  pend_t       pend_q[$];
  int unsigned cyc = 0;
  logic [31:0] exp_addr = 32'h0;
  int          pop_cnt = 0;
  int          max_occ = 0;
  bit          rdy_rand = 1'b0;
  bit          hold_rsp = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          tests = 0;
  int          failed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // Environment: imem responder plus scoreboard feed, sampled 1 time unit before posedge.
  initial begin
    forever begin
      @(negedge d_clk);
      cyc++;
      if (!d_rst) pend_q.delete();
      if (d_rst && !hold_rsp && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        bus.f_i_rsp_valid = 1'b1;
        bus.f_i_rsp_instr = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        bus.f_i_rsp_valid = 1'b0;
        bus.f_i_rsp_instr = 32'h0;
      end
      bus.f_i_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      if (!d_rst) begin
        exp_q.delete();
        exp_addr = 32'h0;
        pop_cnt  = 0;
      end else begin
        if (bus.f_o_valid && !bus.f_i_stall && !bus.f_i_redirect) begin
          pop_cnt++;
          if (exp_q.size() == 0)
            cmp_q.push_back('{"unexpected_head", 64'd1, 64'd0});
          else
            cmp_q.push_back('{"head", {bus.f_o_pc, bus.f_o_instr}, exp_q.pop_front()});
        end
        if (bus.f_i_redirect) begin
          exp_q.delete();
          exp_addr = bus.f_i_redirect_pc;
        end
        if (bus.f_o_req && bus.f_i_req_ready) begin
          cmp_q.push_back('{"req_addr", {32'h0, bus.f_o_req_addr}, {32'h0, exp_addr}});
          pend_q.push_back('{bus.f_o_req_addr,
                             cyc + 32'($urandom_range(lat_min, lat_max))});
          exp_q.push_back({exp_addr, mem_word(exp_addr)});
          exp_addr = exp_addr + 32'd4;
          if (exp_q.size() > max_occ) max_occ = exp_q.size();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge d_clk);
    d_rst = 1'b0;
    bus.f_i_redirect = 1'b0;
    bus.f_i_stall = 1'b0;
    hold_rsp = 1'b0;
    rdy_rand = 1'b0;
    lat_min = 1;
    lat_max = 1;
    repeat (2) @(negedge d_clk);
    d_rst = 1'b1;
  endtask

  task automatic test_reset();
    cmp_t c;
    bus.f_i_ce = 1'b1;
    repeat (6) @(negedge d_clk);
    #2 d_rst = 1'b0;
    #1;
    tests++; if (bus.f_o_req !== 1'b0) begin failed++;
      $display("FAIL rst_req: got %b expected 0", bus.f_o_req); end
    tests++; if (bus.f_o_valid !== 1'b0) begin failed++;
      $display("FAIL rst_valid: got %b expected 0", bus.f_o_valid); end
    tests++; if (bus.f_o_pc !== 32'h0) begin failed++;
      $display("FAIL rst_pc: got %h expected 0", bus.f_o_pc); end
    tests++; if (bus.f_o_instr !== 32'h0) begin failed++;
      $display("FAIL rst_instr: got %h expected 0", bus.f_o_instr); end
    tests++; if (bus.f_o_req_addr !== 32'h0) begin failed++;
      $display("FAIL rst_req_addr: got %h expected 0", bus.f_o_req_addr); end
    repeat (2) @(negedge d_clk);
    d_rst = 1'b1;
    while (cmp_q.size() != 0) begin
      c = cmp_q.pop_front(); tests++;
      if (c.obs !== c.exp) begin failed++;
        $display("FAIL %s: got %h expected %h", c.name, c.obs, c.exp); end
    end
  endtask

  task automatic test_stream();
    cmp_t c;
    int   nval = 0;
    logic first_v = 1'b1;
    do_reset();
    bus.f_i_ce = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (i == 1) first_v = bus.f_o_valid;
      if (i >= 2 && bus.f_o_valid) nval++;
      @(negedge d_clk);
    end
    bus.f_i_ce = 1'b0;
    repeat (6) @(negedge d_clk);
    tests++; if (first_v !== 1'b0) begin failed++;
      $display("FAIL stream_latency: valid %b one cycle after accept, expected 0", first_v); end
    tests++; if (nval != 18) begin failed++;
      $display("FAIL stream_rate: got %0d valid cycles expected 18", nval); end
    tests++; if (exp_q.size() != 0) begin failed++;
      $display("FAIL stream_drained: got %0d pending expected 0", exp_q.size()); end
    while (cmp_q.size() != 0) begin
      c = cmp_q.pop_front(); tests++;
      if (c.obs !== c.exp) begin failed++;
        $display("FAIL %s: got %h expected %h", c.name, c.obs, c.exp); end
    end
  endtask

  task automatic test_stall();
    cmp_t c;
    do_reset();
    bus.f_i_ce = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) bus.f_i_stall = 1'b1;
      @(negedge d_clk);
    end
    #4;
    tests++; if (bus.f_o_req !== 1'b0) begin failed++;
      $display("FAIL stall_req: got %b expected 0", bus.f_o_req); end
    tests++; if (bus.f_o_pc !== 32'h4) begin failed++;
      $display("FAIL stall_head_pc: got %h expected 4", bus.f_o_pc); end
    tests++; if (exp_q.size() != 4) begin failed++;
      $display("FAIL stall_fill: got %0d entries expected 4", exp_q.size()); end
    @(negedge d_clk);
    bus.f_i_stall = 1'b0;
    repeat (12) @(negedge d_clk);
    bus.f_i_ce = 1'b0;
    repeat (8) @(negedge d_clk);
    tests++; if (exp_q.size() != 0) begin failed++;
      $display("FAIL stall_drained: got %0d pending expected 0", exp_q.size()); end
    while (cmp_q.size() != 0) begin
      c = cmp_q.pop_front(); tests++;
      if (c.obs !== c.exp) begin failed++;
        $display("FAIL %s: got %h expected %h", c.name, c.obs, c.exp); end
    end
  endtask

  task automatic test_redirect();
    cmp_t c;
    int   pops_at;
    do_reset();
    bus.f_i_stall = 1'b1;
    bus.f_i_ce = 1'b1;
    repeat (2) @(negedge d_clk);
    bus.f_i_ce = 1'b0;
    repeat (3) @(negedge d_clk);
    // Two words queued; now two more requests left outstanding with responses held.
    hold_rsp = 1'b1;
    bus.f_i_ce = 1'b1;
    repeat (2) @(negedge d_clk);
    bus.f_i_redirect = 1'b1;
    bus.f_i_redirect_pc = 32'h100;
    #4;
    tests++; if (bus.f_o_req !== 1'b0) begin failed++;
      $display("FAIL redir_req: got %b expected 0", bus.f_o_req); end
    @(negedge d_clk);
    bus.f_i_redirect = 1'b0;
    bus.f_i_stall = 1'b0;
    #4;
    pops_at = pop_cnt;
    tests++; if (bus.f_o_valid !== 1'b0) begin failed++;
      $display("FAIL redir_flush: valid %b expected 0", bus.f_o_valid); end
    tests++; if ({bus.f_o_req, bus.f_o_req_addr} !== {1'b1, 32'h100}) begin failed++;
      $display("FAIL redir_first_req: got %b/%h expected 1/100", bus.f_o_req,
               bus.f_o_req_addr); end
    @(negedge d_clk);
    hold_rsp = 1'b0;
    repeat (15) @(negedge d_clk);
    bus.f_i_ce = 1'b0;
    repeat (8) @(negedge d_clk);
    tests++; if (pop_cnt - pops_at < 5) begin failed++;
      $display("FAIL redir_progress: got %0d pops expected at least 5", pop_cnt - pops_at); end
    tests++; if (exp_q.size() != 0) begin failed++;
      $display("FAIL redir_drained: got %0d pending expected 0", exp_q.size()); end
`ifdef FETCH_PERF_EN
    tests++; if (drop_cnt !== 32'd2) begin failed++;
      $display("FAIL perf_drop: got %0d expected 2", drop_cnt); end
    // Two words were flushed by the redirect; everything else was popped.
    tests++; if (fetch_cnt !== 32'(pop_cnt + 2)) begin failed++;
      $display("FAIL perf_fetch: got %0d expected %0d", fetch_cnt, pop_cnt + 2); end
`endif
    while (cmp_q.size() != 0) begin
      c = cmp_q.pop_front(); tests++;
      if (c.obs !== c.exp) begin failed++;
        $display("FAIL %s: got %h expected %h", c.name, c.obs, c.exp); end
    end
  endtask

  task automatic test_redirect_rsp();
    cmp_t c;
    do_reset();
    bus.f_i_ce = 1'b1;
    repeat (6) @(negedge d_clk);
    // Steady stream: a response and a pop coincide with this redirect.
    bus.f_i_redirect = 1'b1;
    bus.f_i_redirect_pc = 32'h200;
    @(negedge d_clk);
    bus.f_i_redirect = 1'b0;
    #4;
    tests++; if (bus.f_o_valid !== 1'b0) begin failed++;
      $display("FAIL redir_rsp_valid: got %b expected 0", bus.f_o_valid); end
    tests++; if (bus.f_o_req_addr !== 32'h200) begin failed++;
      $display("FAIL redir_rsp_addr: got %h expected 200", bus.f_o_req_addr); end
    @(negedge d_clk);
    repeat (10) @(negedge d_clk);
    bus.f_i_ce = 1'b0;
    repeat (6) @(negedge d_clk);
    tests++; if (exp_q.size() != 0) begin failed++;
      $display("FAIL redir_rsp_drained: got %0d pending expected 0", exp_q.size()); end
    while (cmp_q.size() != 0) begin
      c = cmp_q.pop_front(); tests++;
      if (c.obs !== c.exp) begin failed++;
        $display("FAIL %s: got %h expected %h", c.name, c.obs, c.exp); end
    end
  endtask

  task automatic test_random();
    cmp_t c;
    do_reset();
    rdy_rand = 1'b1;
    lat_min = 1;
    lat_max = 3;
    max_occ = 0;
    for (int i = 0; i < 400; i++) begin
      bus.f_i_ce = ($urandom_range(0, 9) != 0);
      bus.f_i_stall = ($urandom_range(0, 3) == 0);
      bus.f_i_redirect = ($urandom_range(0, 39) == 0);
      bus.f_i_redirect_pc = 32'($urandom_range(0, 4095)) << 2;
      @(negedge d_clk);
    end
    bus.f_i_redirect = 1'b0;
    bus.f_i_stall = 1'b0;
    bus.f_i_ce = 1'b0;
    repeat (12) @(negedge d_clk);
    tests++; if (max_occ > 4) begin failed++;
      $display("FAIL rand_occupancy: got %0d expected at most 4", max_occ); end
    tests++; if (exp_q.size() != 0) begin failed++;
      $display("FAIL rand_drained: got %0d pending expected 0", exp_q.size()); end
    tests++; if (pop_cnt < 50) begin failed++;
      $display("FAIL rand_progress: got %0d pops expected at least 50", pop_cnt); end
    while (cmp_q.size() != 0) begin
      c = cmp_q.pop_front(); tests++;
      if (c.obs !== c.exp) begin failed++;
        $display("FAIL %s: got %h expected %h", c.name, c.obs, c.exp); end
    end
  endtask

  initial begin
    bus.f_i_ce = 1'b0;
    bus.f_i_stall = 1'b0;
    bus.f_i_redirect = 1'b0;
    bus.f_i_redirect_pc = 32'h0;
    bus.f_i_req_ready = 1'b1;
    bus.f_i_rsp_valid = 1'b0;
    bus.f_i_rsp_instr = 32'h0;
    repeat (2) @(negedge d_clk);
    d_rst = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
